// File: rtl/spi_slave_cmd_sequencer.sv
// SPI slave command sequencer: walks a received command through address,
// dummy and data phases, issuing register/memory write and read-request pulses.
module spi_slave_cmd_sequencer #(
    parameter int unsigned ADDR_BYTES = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cs_n_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic [7:0]  cmd_o,
    input  logic        get_addr_i,
    input  logic        get_data_i,
    input  logic        send_data_i,
    input  logic        enable_cont_i,
    input  logic        enable_regs_i,
    input  logic        wait_dummy_i,
    input  logic        error_i,
    input  logic [1:0]  reg_sel_i,
    input  logic [7:0]  dummy_len_i,
    output logic [31:0] addr_o,
    output logic [7:0]  wdata_o,
    output logic        reg_we_o,
    output logic [1:0]  reg_sel_o,
    output logic        mem_we_o,
    output logic        rd_req_o,
    output logic        busy_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_ADDR,
        S_DUMMY,
        S_RX,
        S_TX,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    state_t      data_state;
    logic [7:0]  cmd_q, cmd_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  reg_sel_q, reg_sel_d;
    logic        reg_we_q, reg_we_d;
    logic        mem_we_q, mem_we_d;
    logic        rd_req_q, rd_req_d;
    logic        err_q, err_d;
    logic        inc_q, inc_d;

    // Data phase chosen once command decode and addressing are finished.
    always_comb begin
        data_state = S_DONE;
        if (wait_dummy_i && dummy_len_i != 8'd0) begin
            data_state = S_DUMMY;
        end else if (send_data_i) begin
            data_state = S_TX;
        end else if (get_data_i) begin
            data_state = S_RX;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        addr_d    = inc_q ? addr_q + 32'd1 : addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        reg_sel_d = 2'b00;
        reg_we_d  = 1'b0;
        mem_we_d  = 1'b0;
        rd_req_d  = 1'b0;
        err_d     = 1'b0;
        inc_d     = 1'b0;

        if (state_q != S_IDLE && cs_n_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (!cs_n_i && rx_valid_i) begin
                        cmd_d   = rx_data_i;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    cnt_d = 8'd0;
                    if (error_i) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else if (get_addr_i) begin
                        state_d = S_ADDR;
                    end else begin
                        state_d = data_state;
                    end
                end
                S_ADDR: begin
                    if (rx_valid_i) begin
                        addr_d = {addr_q[23:0], rx_data_i};
                        cnt_d  = cnt_q + 8'd1;
                        if (cnt_q == 8'(ADDR_BYTES - 1)) begin
                            cnt_d   = 8'd0;
                            state_d = data_state;
                        end
                    end
                end
                S_DUMMY: begin
                    if (rx_valid_i) begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q == dummy_len_i - 8'd1) begin
                            state_d = send_data_i ? S_TX : S_RX;
                        end
                    end
                end
                S_RX: begin
                    if (rx_valid_i) begin
                        wdata_d = rx_data_i;
                        if (enable_regs_i) begin
                            reg_we_d  = 1'b1;
                            reg_sel_d = reg_sel_i;
                        end else begin
                            mem_we_d = 1'b1;
                        end
                        // Address advances the cycle after the write pulse.
                        inc_d = enable_cont_i && !enable_regs_i;
                        if (!enable_cont_i) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_TX: begin
                    if (rx_valid_i) begin
                        if (enable_cont_i) begin
                            rd_req_d = 1'b1;
                            if (enable_regs_i) begin
                                reg_sel_d = reg_sel_i;
                            end else begin
                                addr_d = addr_q + 32'd1;
                            end
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
            endcase
        end

        if (state_d == S_TX && state_q != S_TX) begin
            rd_req_d  = 1'b1;
            reg_sel_d = enable_regs_i ? reg_sel_i : 2'b00;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cmd_q     <= 8'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 8'd0;
            cnt_q     <= 8'd0;
            reg_sel_q <= 2'b00;
            reg_we_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            rd_req_q  <= 1'b0;
            err_q     <= 1'b0;
            inc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            reg_sel_q <= reg_sel_d;
            reg_we_q  <= reg_we_d;
            mem_we_q  <= mem_we_d;
            rd_req_q  <= rd_req_d;
            err_q     <= err_d;
            inc_q     <= inc_d;
        end
    end

    assign cmd_o     = cmd_q;
    assign addr_o    = addr_q;
    assign wdata_o   = wdata_q;
    assign reg_we_o  = reg_we_q;
    assign reg_sel_o = reg_sel_q;
    assign mem_we_o  = mem_we_q;
    assign rd_req_o  = rd_req_q;
    assign err_o     = err_q;
    assign busy_o    = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_slave_cmd_sequencer.sv
// Bench for spi_slave_cmd_sequencer.
// Directed cases plus random transactions.
module tb_spi_slave_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cs_n_i;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic [7:0]  cmd_o;
  logic        get_addr_i;
  logic        get_data_i;
  logic        send_data_i;
  logic        enable_cont_i;
  logic        enable_regs_i;
  logic        wait_dummy_i;
  logic        error_i;
  logic [1:0]  reg_sel_i;
  logic [7:0]  dummy_len_i;
  logic [31:0] addr_o;
  logic [7:0]  wdata_o;
  logic        reg_we_o;
  logic [1:0]  reg_sel_o;
  logic        mem_we_o;
  logic        rd_req_o;
  logic        busy_o;
  logic        err_o;

  int total = 0;
  int bad = 0;
  int viol = 0;

  logic [7:0]  pay[$];
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  logic [31:0] m_addr;

  spi_slave_cmd_sequencer dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .cs_n_i(cs_n_i),
    .rx_valid_i(rx_valid_i),
    .rx_data_i(rx_data_i),
    .cmd_o(cmd_o),
    .get_addr_i(get_addr_i),
    .get_data_i(get_data_i),
    .send_data_i(send_data_i),
    .enable_cont_i(enable_cont_i),
    .enable_regs_i(enable_regs_i),
    .wait_dummy_i(wait_dummy_i),
    .error_i(error_i),
    .reg_sel_i(reg_sel_i),
    .dummy_len_i(dummy_len_i),
    .addr_o(addr_o),
    .wdata_o(wdata_o),
    .reg_we_o(reg_we_o),
    .reg_sel_o(reg_sel_o),
    .mem_we_o(mem_we_o),
    .rd_req_o(rd_req_o),
    .busy_o(busy_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] o,
    input logic [63:0] e
  );
    total++;
    if (o !== e) begin
      bad++;
      $error("FAIL %s: obs=%0h exp=%0h",
             tag, o, e);
    end
  endtask

  function automatic logic [63:0] ev(
    input logic [3:0]  k,
    input logic [1:0]  s,
    input logic [7:0]  d,
    input logic [31:0] a
  );
    return {18'd0, k, s, d, a};
  endfunction

  always @(negedge clk) begin
    if (int'(reg_we_o) + int'(mem_we_o)
        + int'(rd_req_o) > 1)
      viol++;
    if (reg_we_o)
      obs_q.push_back(
        ev(4'd1, reg_sel_o, wdata_o, addr_o));
    if (mem_we_o)
      obs_q.push_back(
        ev(4'd2, 2'b00, wdata_o, addr_o));
    if (rd_req_o)
      obs_q.push_back(
        ev(4'd3,
           enable_regs_i ? reg_sel_o : 2'b00,
           8'd0, addr_o));
    if (err_o)
      obs_q.push_back(
        ev(4'd4, 2'b00, 8'd0, 32'd0));
  end

  task automatic set_flags(
    input logic       e,
    input logic       ga,
    input logic       gd,
    input logic       sd,
    input logic       cont,
    input logic       regs,
    input logic       wd,
    input logic [7:0] dl,
    input logic [1:0] sel
  );
    error_i = e;
    get_addr_i = ga;
    get_data_i = gd;
    send_data_i = sd;
    enable_cont_i = cont;
    enable_regs_i = regs;
    wait_dummy_i = wd;
    dummy_len_i = dl;
    reg_sel_i = sel;
  endtask

  task automatic model();
    int i = 0;
    int got = 0;
    int md;
    logic [1:0] rs;
    rs = enable_regs_i ? reg_sel_i : 2'b00;
    if (error_i) begin
      exp_q.push_back(
        ev(4'd4, 2'b00, 8'd0, 32'd0));
      return;
    end
    if (get_addr_i) begin
      while (got < 4 && i < pay.size()) begin
        m_addr = {m_addr[23:0], pay[i]};
        i++;
        got++;
      end
      if (got < 4) return;
    end
    if (wait_dummy_i && dummy_len_i != 0) begin
      if (pay.size() - i < int'(dummy_len_i))
        return;
      i += int'(dummy_len_i);
      md = send_data_i ? 2 : 1;
    end else begin
      md = send_data_i ? 2 :
           (get_data_i ? 1 : 0);
    end
    if (md == 2) begin
      exp_q.push_back(
        ev(4'd3, rs, 8'd0, m_addr));
      for (; i < pay.size(); i++) begin
        if (!enable_cont_i) break;
        if (!enable_regs_i)
          m_addr = m_addr + 32'd1;
        exp_q.push_back(
          ev(4'd3, rs, 8'd0, m_addr));
      end
    end else if (md == 1) begin
      for (; i < pay.size(); i++) begin
        if (enable_regs_i)
          exp_q.push_back(
            ev(4'd1, reg_sel_i, pay[i], m_addr));
        else
          exp_q.push_back(
            ev(4'd2, 2'b00, pay[i], m_addr));
        if (enable_cont_i && !enable_regs_i)
          m_addr = m_addr + 32'd1;
        if (!enable_cont_i) break;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid_i = 1'b1;
    rx_data_i = b;
    @(posedge clk); #1;
    rx_valid_i = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  task automatic compare_events();
    chk("event_count", obs_q.size(),
        exp_q.size());
    for (int k = 0;
         k < exp_q.size() && k < obs_q.size();
         k++)
      chk("event", obs_q[k], exp_q[k]);
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic run_txn(input logic [7:0] cmd);
    model();
    #1 cs_n_i = 1'b0;
    send_byte(cmd);
    for (int k = 0; k < pay.size(); k++)
      send_byte(pay[k]);
    repeat (2) @(posedge clk);
    chk("cmd_hold", cmd_o, cmd);
    #1 cs_n_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("idle_after_cs", busy_o, 1'b0);
    chk("addr_track", addr_o, m_addr);
    compare_events();
  endtask

  initial begin
    rst_i = 1'b1;
    cs_n_i = 1'b1;
    rx_valid_i = 1'b0;
    rx_data_i = 8'd0;
    set_flags(0, 0, 0, 0, 0, 0, 0,
              8'd0, 2'b00);
    m_addr = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_cmd", cmd_o, 8'h00);
    chk("rst_addr", addr_o, 32'h0);
    chk("rst_wdata", wdata_o, 8'h00);
    chk("rst_pulses",
        {reg_we_o, mem_we_o, rd_req_o, err_o},
        4'b0000);
    chk("rst_sel", reg_sel_o, 2'b00);
    obs_q.delete();

    set_flags(0, 1, 1, 0, 1, 0, 0,
              8'd0, 2'b00);
    pay = {8'h00, 8'h00, 8'h10, 8'h00,
           8'hAA, 8'hBB};
    run_txn(8'h02);
    chk("cont_write_addr", addr_o,
        32'h0000_1002);

    set_flags(0, 1, 0, 1, 1, 0, 1,
              8'd2, 2'b00);
    pay = {8'hFF, 8'hFF, 8'hFF, 8'hFF,
           8'h00, 8'h00, 8'h00};
    run_txn(8'h0B);
    chk("read_wrap_addr", addr_o, 32'h0);

    set_flags(0, 0, 1, 0, 0, 1, 0,
              8'd0, 2'b10);
    pay = {8'h5A, 8'h77};
    run_txn(8'h20);

    set_flags(1, 0, 1, 1, 1, 0, 0,
              8'd0, 2'b00);
    pay = {8'h44};
    model();
    #1 cs_n_i = 1'b0;
    @(posedge clk); #1;
    rx_valid_i = 1'b1;
    rx_data_i = 8'hFF;
    @(posedge clk); #1;
    rx_valid_i = 1'b0;
    @(negedge clk);
    chk("err_early", err_o, 1'b0);
    @(negedge clk);
    chk("err_pulse", err_o, 1'b1);
    @(negedge clk);
    chk("err_once", err_o, 1'b0);
    send_byte(8'h44);
    chk("err_busy", busy_o, 1'b1);
    #1 cs_n_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("err_idle", busy_o, 1'b0);
    compare_events();

    set_flags(0, 1, 1, 0, 1, 0, 0,
              8'd0, 2'b00);
    pay = {8'h12, 8'h34};
    run_txn(8'h03);

    set_flags(0, 0, 1, 0, 1, 0, 0,
              8'd0, 2'b00);
    pay = {8'h11};
    model();
    #1 cs_n_i = 1'b0;
    send_byte(8'h02);
    send_byte(8'h11);
    chk("rx_busy", busy_o, 1'b1);
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    m_addr = 32'd0;
    @(negedge clk);
    chk("rst_mid_busy", busy_o, 1'b0);
    chk("rst_mid_cmd", cmd_o, 8'h00);
    chk("rst_mid_addr", addr_o, 32'h0);
    cs_n_i = 1'b1;
    repeat (2) @(posedge clk);
    compare_events();

    for (int t = 0; t < 24; t++) begin
      int n;
      set_flags(($urandom % 8) == 0,
                1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom),
                8'($urandom % 4),
                2'($urandom));
      n = $urandom_range(0, 11);
      pay.delete();
      for (int k = 0; k < n; k++)
        pay.push_back(
          (($urandom % 3) == 0) ? 8'hFF :
          8'($urandom));
      run_txn(8'($urandom));
      repeat (2) @(posedge clk);
    end

    chk("one_hot", viol, 0);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
